// File: rtl/motoro3_pwm_capture.sv
// Measures delivered PWM high time per period and per commutation step, and flags short or stuck pulses.
// Latency: highValid/stepValid one clk after the strobe; no backpressure, results are single-cycle strobes.
module motoro3_pwm_capture #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] MAX_HIGH    = 16'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        pwmIn,
   input  logic        periodEnd,
   input  logic        stepEnd,
   input  logic [3:0]  sgStep,
   input  logic [15:0] wantLen,
   input  logic [11:0] minPulse,
   input  logic        errClr,
   output logic [15:0] highCnt,
   output logic        highValid,
   output logic [15:0] stepReal,
   output logic [15:0] stepWant,
   output logic [15:0] stepLost,
   output logic [3:0]  stepNum,
   output logic        stepValid,
   output logic        shortErr,
   output logic [7:0]  shortCnt,
   output logic        stuckErr
);

   typedef enum logic [1:0] {S_LOW, S_HIGH, S_STUCK} state_t;

   logic        pwmS;
   logic [15:0] perCnt_q, realAcc_q, wantAcc_q;
   logic [15:0] highCnt_q, stepReal_q, stepWant_q, stepLost_q;
   logic [3:0]  stepNum_q;
   logic        highValid_q, stepValid_q;
   logic [16:0] perSum;
   logic [15:0] perSat, realNext, wantNext, runInc;
   state_t      state_q, state_d;
   logic [15:0] runCnt_q, runCnt_d;
   logic        shortEvt, stuckEvt;
   logic        shortErr_q, shortErr_d, stuckErr_q, stuckErr_d;
   logic [7:0]  shortCnt_q, shortCnt_d;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign pwmS = pwmIn;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= pwmIn;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign pwmS = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // The cycle carrying periodEnd still counts toward the ending period.
   assign perSum   = {1'b0, perCnt_q} + {16'd0, pwmS};
   assign perSat   = perSum[16] ? 16'hFFFF : perSum[15:0];
   assign realNext = realAcc_q + (periodEnd ? perSat : 16'd0);
   assign wantNext = wantAcc_q + (periodEnd ? wantLen : 16'd0);
   assign runInc   = runCnt_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         perCnt_q    <= '0;
         realAcc_q   <= '0;
         wantAcc_q   <= '0;
         highCnt_q   <= '0;
         highValid_q <= 1'b0;
         stepReal_q  <= '0;
         stepWant_q  <= '0;
         stepLost_q  <= '0;
         stepNum_q   <= 4'hF;
         stepValid_q <= 1'b0;
      end else begin
         highValid_q <= periodEnd;
         stepValid_q <= stepEnd;
         perCnt_q    <= periodEnd ? 16'd0 : perSat;
         if (periodEnd) highCnt_q <= perSat;
         if (stepEnd) begin
            stepReal_q <= realNext;
            stepWant_q <= wantNext;
            stepLost_q <= wantNext - realNext;
            stepNum_q  <= sgStep;
            realAcc_q  <= '0;
            wantAcc_q  <= '0;
         end else begin
            realAcc_q  <= realNext;
            wantAcc_q  <= wantNext;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      runCnt_d = runCnt_q;
      shortEvt = 1'b0;
      stuckEvt = 1'b0;
      if (!enable) begin
         state_d  = S_LOW;
         runCnt_d = '0;
      end else begin
         case (state_q)
            S_LOW: if (pwmS) begin
               state_d  = S_HIGH;
               runCnt_d = 16'd1;
            end
            S_HIGH: if (pwmS) begin
               runCnt_d = runInc;
               if (runInc == MAX_HIGH) begin
                  state_d  = S_STUCK;
                  stuckEvt = 1'b1;
               end
            end else begin
               state_d = S_LOW;
               if (minPulse != 12'd0 && runCnt_q < {4'd0, minPulse}) shortEvt = 1'b1;
            end
            S_STUCK: if (!pwmS) state_d = S_LOW;
            default: state_d = S_LOW;
         endcase
      end
   end

   // A clear and an error event in the same cycle leave the event recorded.
   always_comb begin
      shortErr_d = errClr ? 1'b0 : shortErr_q;
      shortCnt_d = errClr ? 8'd0 : shortCnt_q;
      stuckErr_d = errClr ? 1'b0 : stuckErr_q;
      if (shortEvt) begin
         shortErr_d = 1'b1;
         if (shortCnt_d != 8'hFF) shortCnt_d = shortCnt_d + 8'd1;
      end
      if (stuckEvt) stuckErr_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LOW;
         runCnt_q   <= '0;
         shortErr_q <= 1'b0;
         shortCnt_q <= '0;
         stuckErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         runCnt_q <= runCnt_d;
         if (enable) begin
            shortErr_q <= shortErr_d;
            shortCnt_q <= shortCnt_d;
            stuckErr_q <= stuckErr_d;
         end
      end
   end

   assign highCnt   = highCnt_q;
   assign highValid = highValid_q;
   assign stepReal  = stepReal_q;
   assign stepWant  = stepWant_q;
   assign stepLost  = stepLost_q;
   assign stepNum   = stepNum_q;
   assign stepValid = stepValid_q;
   assign shortErr  = shortErr_q;
   assign shortCnt  = shortCnt_q;
   assign stuckErr  = stuckErr_q;

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Directed bench for motoro3_pwm_capture; expected period/step results are queued as stimulus is driven.
module tb_motoro3_pwm_capture;

   logic        clk = 1'b0;
   logic        rst, enable, pwmIn, periodEnd, stepEnd, errClr;
   logic [3:0]  sgStep;
   logic [15:0] wantLen;
   logic [11:0] minPulse;
   logic [15:0] highCnt, stepReal, stepWant, stepLost;
   logic        highValid, stepValid, shortErr, stuckErr;
   logic [3:0]  stepNum;
   logic [7:0]  shortCnt;

   always #50 clk = ~clk;

   motoro3_pwm_capture #(.SYNC_STAGES(2), .MAX_HIGH(16'hFFF)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pwmIn(pwmIn),
      .periodEnd(periodEnd), .stepEnd(stepEnd), .sgStep(sgStep),
      .wantLen(wantLen), .minPulse(minPulse), .errClr(errClr),
      .highCnt(highCnt), .highValid(highValid), .stepReal(stepReal),
      .stepWant(stepWant), .stepLost(stepLost), .stepNum(stepNum),
      .stepValid(stepValid), .shortErr(shortErr), .shortCnt(shortCnt),
      .stuckErr(stuckErr)
   );

   typedef struct {
      logic [15:0] r;
      logic [15:0] w;
      logic [15:0] l;
      logic [3:0]  n;
   } step_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_high[$];
   step_t       exp_step[$];
   logic [15:0] m_real, m_want;
   logic [15:0] e_high;
   step_t       e_step;
   logic        pe_prev = 1'b0;
   logic        se_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One PWM period: up to two pulses, optional stepEnd at cycle step_at (-1 = none).
   task automatic run_period(input int hi1, input int gap, input int hi2, input int len,
                             input logic [15:0] want, input int step_at);
      for (int c = 0; c < len; c++) begin
         pwmIn     = (c < hi1) || (c >= hi1 + gap && c < hi1 + gap + hi2);
         periodEnd = (c == len - 1);
         stepEnd   = (c == step_at);
         wantLen   = want;
         if (periodEnd) begin
            exp_high.push_back(16'(hi1 + hi2));
            m_real += 16'(hi1 + hi2);
            m_want += want;
         end
         if (stepEnd) begin
            exp_step.push_back('{m_real, m_want, 16'(m_want - m_real), sgStep});
            m_real = '0;
            m_want = '0;
         end
         tick();
      end
      pwmIn     = 1'b0;
      periodEnd = 1'b0;
      stepEnd   = 1'b0;
   endtask

   always @(negedge clk) begin
      if (highValid === 1'b1 || pe_prev) chk("highValid_latency", {31'd0, highValid}, {31'd0, pe_prev});
      if (stepValid === 1'b1 || se_prev) chk("stepValid_latency", {31'd0, stepValid}, {31'd0, se_prev});
      if (highValid === 1'b1) begin
         checks++;
         assert (exp_high.size() != 0) else begin
            errors++;
            $error("FAIL highValid_spurious: observed highCnt %0h expected no result", highCnt);
         end
         if (exp_high.size() != 0) begin
            e_high = exp_high.pop_front();
            chk("highCnt", {16'd0, highCnt}, {16'd0, e_high});
         end
      end
      if (stepValid === 1'b1) begin
         checks++;
         assert (exp_step.size() != 0) else begin
            errors++;
            $error("FAIL stepValid_spurious: observed stepReal %0h expected no result", stepReal);
         end
         if (exp_step.size() != 0) begin
            e_step = exp_step.pop_front();
            chk("stepReal", {16'd0, stepReal}, {16'd0, e_step.r});
            chk("stepWant", {16'd0, stepWant}, {16'd0, e_step.w});
            chk("stepLost", {16'd0, stepLost}, {16'd0, e_step.l});
            chk("stepNum",  {28'd0, stepNum},  {28'd0, e_step.n});
         end
      end
      pe_prev = periodEnd;
      se_prev = stepEnd;
   end

   initial begin
      rst = 1'b1; enable = 1'b1; pwmIn = 1'b0; periodEnd = 1'b0; stepEnd = 1'b0;
      errClr = 1'b0; sgStep = 4'd0; wantLen = 16'd0; minPulse = 12'd0;
      m_real = '0; m_want = '0;
      repeat (3) tick();
      chk("rst_highCnt",   {16'd0, highCnt},   32'd0);
      chk("rst_highValid", {31'd0, highValid}, 32'd0);
      chk("rst_stepReal",  {16'd0, stepReal},  32'd0);
      chk("rst_stepLost",  {16'd0, stepLost},  32'd0);
      chk("rst_stepNum",   {28'd0, stepNum},   32'hF);
      chk("rst_shortCnt",  {24'd0, shortCnt},  32'd0);
      chk("rst_stuckErr",  {31'd0, stuckErr},  32'd0);
      rst = 1'b0;
      tick();

      // 100-cycle pulse in a 409-cycle period, closing a step on the same strobe
      sgStep = 4'd1;
      run_period(100, 0, 0, 409, 16'd100, 408);

      // six 120-high periods wanting 128 each
      sgStep = 4'd7;
      repeat (5) run_period(120, 0, 0, 200, 16'd128, -1);
      run_period(120, 0, 0, 200, 16'd128, 199);

      // over-delivery gives a negative loss
      sgStep = 4'd3;
      run_period(130, 0, 0, 200, 16'd100, -1);
      run_period(130, 0, 0, 200, 16'd100, 199);

      // 31-cycle pulse is short, 32-cycle pulse is legal
      minPulse = 12'd32;
      sgStep   = 4'd4;
      run_period(31, 10, 32, 200, 16'd63, 199);
      chk("short_cnt",   {24'd0, shortCnt}, 32'd1);
      chk("short_err",   {31'd0, shortErr}, 32'd1);
      chk("short_stuck", {31'd0, stuckErr}, 32'd0);
      errClr = 1'b1;
      tick();
      errClr = 1'b0;
      chk("clr_shortCnt", {24'd0, shortCnt}, 32'd0);
      chk("clr_shortErr", {31'd0, shortErr}, 32'd0);

      // line held high 5000 cycles; stuck flagged 4095 cycles after the synchronised rise
      sgStep = 4'd9;
      for (int c = 0; c < 5100; c++) begin
         pwmIn     = (c < 5000);
         periodEnd = (c == 5099);
         stepEnd   = (c == 5099);
         wantLen   = 16'd4000;
         if (periodEnd) begin
            exp_high.push_back(16'd5000);
            m_real += 16'd5000;
            m_want += 16'd4000;
            exp_step.push_back('{m_real, m_want, 16'(m_want - m_real), sgStep});
            m_real = '0;
            m_want = '0;
         end
         tick();
         if (c == 4095) chk("stuck_early", {31'd0, stuckErr}, 32'd0);
         if (c == 4096) chk("stuck_onset", {31'd0, stuckErr}, 32'd1);
      end
      pwmIn = 1'b0; periodEnd = 1'b0; stepEnd = 1'b0;
      repeat (4) tick();
      chk("stuck_hold",     {31'd0, stuckErr}, 32'd1);
      chk("stuck_no_short", {31'd0, shortErr}, 32'd0);
      chk("stuck_shortCnt", {24'd0, shortCnt}, 32'd0);

      // disable mid-step clears measurement state but keeps error flags
      sgStep = 4'd2;
      run_period(50, 0, 0, 200, 16'd60, -1);
      enable = 1'b0;
      m_real = '0;
      m_want = '0;
      repeat (3) tick();
      chk("dis_highCnt",  {16'd0, highCnt},  32'd0);
      chk("dis_stepReal", {16'd0, stepReal}, 32'd0);
      chk("dis_stepWant", {16'd0, stepWant}, 32'd0);
      chk("dis_stepNum",  {28'd0, stepNum},  32'hF);
      chk("dis_stuckErr", {31'd0, stuckErr}, 32'd1);
      enable = 1'b1;
      tick();
      run_period(40, 0, 0, 200, 16'd50, -1);
      run_period(40, 0, 0, 200, 16'd50, 199);

      // step ending mid-period: the partial period carries into the next step
      sgStep = 4'd6;
      run_period(70, 0, 0, 200, 16'd80, -1);
      run_period(60, 0, 0, 200, 16'd64, 150);
      sgStep = 4'd8;
      run_period(30, 0, 0, 200, 16'd30, 199);

      repeat (5) tick();
      chk("high_queue_drained", exp_high.size(), 32'd0);
      chk("step_queue_drained", exp_step.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
